// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
// Used by score_counter_bcd and its per-digit sub-module bcd_digit.
package score_pkg;

  // Game phases: waiting before the first game, playing, finished.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  // One packed BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // Largest legal digit value; a digit at BCD_MAX rolls to 0 with carry.
  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Width of the tick prescaler.
  localparam int PRESC_W = 8;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the score counter.
// The digit steps when the global increment is active and every lower digit
// is at 9 (carry_in); carry_out tells the next digit that it must step too.
module bcd_digit
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  input  logic       carry_in,
  output bcd_digit_t value,
  output logic       carry_out
);

  bcd_digit_t r_value;

  // Ripple is combinational so the whole score updates on a single edge.
  assign carry_out = carry_in && (r_value == BCD_MAX);
  assign value     = r_value;

  // Digit register: clear on new game, decimal step on increment.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (clear) begin
      r_value <= '0;
    end else if (inc && carry_in) begin
      r_value <= (r_value == BCD_MAX) ? '0 : r_value + 4'd1;
    end
  end

endmodule

// File: rtl/score_counter_bcd.sv
// Arcade-style BCD score counter with game FSM, tick prescaler, saturation,
// milestone pulse and optional best-score tracking.
// Optional feature: define SCORE_HISCORE_EN to build the high_score register,
// comparator and new_high pulse; otherwise both outputs are tied to 0.
module score_counter_bcd
  import score_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_POINT = 6,
  parameter int MILESTONE_DIGIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                game_start,
  input  logic                game_over,
  input  logic                game_tick,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] high_score,
  output logic                running,
  output logic                milestone,
  output logic                new_high
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_POINT - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_tick_prev;
  logic [PRESC_W-1:0] r_prescaler;
  logic               r_running;
  logic               r_milestone;

  logic               w_clear;
  logic               w_tick_edge;
  logic               w_count;
  logic               w_point;
  logic               w_inc;
  logic [DIGITS:0]    w_carry;

  // A new game may only be started from outside RUN.
  assign w_clear     = (r_state != RUN) && game_start;
  assign w_tick_edge = game_tick && !r_tick_prev;
  // A tick arriving together with game_over belongs to the finished game.
  assign w_count     = (r_state == RUN) && !game_over && w_tick_edge;
  assign w_point     = w_count && (r_prescaler == PRESC_LAST);
  // Carry out of the top digit means all digits are 9: drop the point.
  assign w_carry[0]  = 1'b1;
  assign w_inc       = w_point && !w_carry[DIGITS];

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .inc       (w_inc),
        .carry_in  (w_carry[g]),
        .value     (score[4*g +: 4]),
        .carry_out (w_carry[g+1])
      );
    end
  endgenerate

  // Next-state logic; game_over wins over game_start while in RUN.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, OVER: if (game_start) w_state_next = RUN;
      RUN:        if (game_over)  w_state_next = OVER;
      default:    w_state_next = IDLE;
    endcase
  end

  // State register plus the registered copy of the RUN indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == RUN);
    end
  end

  // Tick edge detector and prescaler; both restart with a new game.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_prev <= 1'b0;
      r_prescaler <= '0;
    end else if (w_clear) begin
      r_tick_prev <= 1'b0;
      r_prescaler <= '0;
    end else begin
      r_tick_prev <= game_tick;
      if (w_count) begin
        r_prescaler <= w_point ? '0 : r_prescaler + PRESC_W'(1);
      end
    end
  end

  // Milestone pulses on the same edge as the score step that carries into
  // the milestone digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_milestone <= 1'b0;
    end else begin
      r_milestone <= w_inc && w_carry[MILESTONE_DIGIT];
    end
  end

  assign running   = r_running;
  assign milestone = r_milestone;

`ifdef SCORE_HISCORE_EN
  logic [4*DIGITS-1:0] r_high_score;
  logic                r_new_high;
  logic                w_finish;

  assign w_finish = (r_state == RUN) && game_over;

  // Best final score; packed BCD orders exactly like its unsigned value, so
  // a plain magnitude compare is the MSD-first digit compare. Ties keep the
  // stored score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_score <= '0;
      r_new_high   <= 1'b0;
    end else begin
      r_new_high <= 1'b0;
      if (w_finish && (score > r_high_score)) begin
        r_high_score <= score;
        r_new_high   <= 1'b1;
      end
    end
  end

  assign high_score = r_high_score;
  assign new_high   = r_new_high;
`else
  assign high_score = '0;
  assign new_high   = 1'b0;
`endif

endmodule

// File: doc/score_counter_bcd.md
SCORE_COUNTER_BCD -- requirements
Module: score_counter_bcd

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD score digits, legal range 2..6.
REQ-002 SHALL have parameter TICKS_PER_POINT, default 6: game_tick rising edges per +1 score, legal range 1..255.
REQ-003 SHALL have parameter MILESTONE_DIGIT, default 2: milestone pulses on carry into this digit index (2 = every 100 points), legal range 1..DIGITS-1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 game_start  input  1  synchronous level/pulse; starts a new game.
REQ-007 game_over  input  1  synchronous level/pulse; ends the running game.
REQ-008 game_tick  input  1  frame strobe (nominal 60 Hz); only its rising edge counts.
REQ-009 score  output  4*DIGITS  current score, packed BCD, digit 0 in the LSBs.
REQ-010 high_score  output  4*DIGITS  best final score since reset, packed BCD.
REQ-011 running  output  1  high while in RUN.
REQ-012 milestone  output  1  one-cycle pulse on each carry into digit MILESTONE_DIGIT.
REQ-013 new_high  output  1  one-cycle pulse when a finished game beats high_score.

Function
REQ-014 SHALL implement FSM IDLE, RUN, OVER; reset state IDLE.
REQ-015 IDLE/OVER -> RUN when game_start=1; on that edge score, prescaler and tick-edge register SHALL clear to 0.
REQ-016 RUN -> OVER when game_over=1; game_over SHALL take priority over game_start in the same cycle while in RUN.
REQ-017 In IDLE and OVER game_tick SHALL be ignored; score SHALL hold its last value in OVER.
REQ-018 SHALL detect game_tick rising edge using a registered previous value; a held-high tick counts once.
REQ-019 In RUN each detected edge SHALL increment an 8-bit prescaler; when prescaler reaches TICKS_PER_POINT-1 it SHALL wrap to 0 and score SHALL +1 on the same clock edge.
REQ-020 score SHALL be visible one clock after the cycle in which the tick edge is sampled.
REQ-021 Increment SHALL be decimal: digit 9 -> 0 with carry into the next digit.
REQ-022 At all-9s score SHALL saturate (no wrap) and further points SHALL be dropped without milestone.
REQ-023 A tick edge in the same cycle as game_over SHALL NOT be counted.
REQ-024 milestone SHALL pulse for exactly one cycle, in the cycle score updates, when the carry ripples into digit MILESTONE_DIGIT.
REQ-025 On RUN -> OVER, if score > high_score (BCD compare, MSD first), high_score SHALL load score the next cycle and new_high SHALL pulse once that cycle; equal scores SHALL NOT update.
REQ-026 running SHALL be registered and equal (state==RUN).

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, score 0, high_score 0, prescaler 0, tick register 0, running 0, milestone 0, new_high 0.
REQ-028 Reset mid-game SHALL lose both score and high_score; first cycle after release behaves as IDLE.

Configuration
REQ-029 Macro SCORE_HISCORE_EN defined: high_score register, comparator and new_high logic compiled in per REQ-025.
REQ-030 SCORE_HISCORE_EN undefined: high_score SHALL be constant 0, new_high constant 0, no comparator/register synthesised; all other behaviour unchanged.

Structure
REQ-031 Package score_pkg SHALL hold the state enum (IDLE, RUN, OVER), the bcd_digit_t 4-bit typedef and the constant BCD_MAX = 4'd9.
REQ-032 Sub-module bcd_digit SHALL implement one digit: inc, clear, carry_in -> value, carry_out; instantiated DIGITS times via generate.
REQ-033 Prescaler, edge detect, FSM and high-score compare SHALL stay in the top module.

Verification
REQ-034 Defaults; start, 60 tick edges, over -> score 0x0010, running 1->0, high_score 0x0010, new_high one pulse.
REQ-035 Defaults; start, 600 tick edges -> score 0x0100, exactly one milestone pulse on the 99->100 transition.
REQ-036 DIGITS=2, TICKS_PER_POINT=1; start, 120 edges -> score 0x99 after 99 edges, stays 0x99, no milestone after saturation.
REQ-037 game_tick held high 20 cycles with TICKS_PER_POINT=1 -> score +1 only; game_start and game_over same cycle in RUN -> OVER, score held.
REQ-038 Game1 scores 0x0005, game2 0x0003, game3 0x0005 -> high_score 0x0005, new_high only after game1; without SCORE_HISCORE_EN high_score stays 0.
REQ-039 rst_n low mid-RUN at score 0x0042 -> same-cycle asynchronous clear of all outputs, state IDLE after release.
